// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared state enum, S-box and rotation constants for the ASCON round engine
package ascon_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [2:0] {IDLE, LOAD, DIFFUSE, OUTPUT, DONE} perm_state_e;

  // Two rotate-right amounts per word for the linear diffusion layer, x0..x4
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  // Column index has x0 in bit 4 and x4 in bit 0
  localparam logic [4:0] SBOX_TBL [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [4:0] sbox(input logic [4:0] s);
    return SBOX_TBL[s];
  endfunction

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int r);
    return (x >> r) | (x << (WORD_W - r));
  endfunction

endpackage

// File: rtl/perm_state_regs.sv
// rtl/perm_state_regs.sv - five 64-bit state words with column S-box insert, linear layer and output rotate
module perm_state_regs
  import ascon_pkg::*;
#(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_en,
  input  logic           diffuse_en,
  input  logic           rotate_en,
  input  logic [5*W-1:0] input_data,
  input  logic [W-1:0]   constant,
  output logic [5*W-1:0] top_column
);

  logic [WORD_W-1:0] x [5];
  logic [5*W-1:0]    col_in;
  logic [4:0]        s;
  logic [4:0]        t;

  // Word xk lives in bit slice (4-k)*W of a column group, so slice j maps to S-box bit j
  always_comb begin
    col_in = '0;
    s      = '0;
    t      = '0;
    for (int b = 0; b < W; b++) begin
      for (int j = 0; j < 5; j++) s[j] = input_data[j*W + b];
      s[2] = s[2] ^ constant[b];
      t    = sbox(s);
      for (int j = 0; j < 5; j++) col_in[j*W + b] = t[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 5; k++) x[k] <= '0;
    end else if (load_en) begin
      for (int k = 0; k < 5; k++) x[k] <= {x[k][WORD_W-1-W:0], col_in[(4-k)*W +: W]};
    end else if (diffuse_en) begin
      for (int k = 0; k < 5; k++) x[k] <= x[k] ^ ror(x[k], ROT_A[k]) ^ ror(x[k], ROT_B[k]);
    end else if (rotate_en) begin
      for (int k = 0; k < 5; k++) x[k] <= {x[k][WORD_W-1-W:0], x[k][WORD_W-1 -: W]};
    end
  end

  always_comb begin
    top_column = '0;
    for (int k = 0; k < 5; k++) top_column[(4-k)*W +: W] = x[k][WORD_W-1 -: W];
  end

endmodule

// File: rtl/one_round_permutation.sv
// rtl/one_round_permutation.sv - bit-serial single ASCON p1 round; PERM_DONE_EN adds a perm_done pulse
module one_round_permutation
  import ascon_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [5*BITS_PER_CYCLE-1:0] input_data,
  input  logic [BITS_PER_CYCLE-1:0]   constant,
  input  logic                        start_permutation,
  output logic [5*BITS_PER_CYCLE-1:0] output_data
`ifdef PERM_DONE_EN
  ,
  output logic                        perm_done
`endif
);

  localparam int         N    = WORD_W / BITS_PER_CYCLE;
  localparam logic [6:0] LAST = 7'(N - 1);

  perm_state_e state, state_next;
  logic [6:0]  cnt, cnt_next;
  logic        load_en, diffuse_en, rotate_en;
  logic [5*BITS_PER_CYCLE-1:0] top_column;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_en    = 1'b0;
    diffuse_en = 1'b0;
    rotate_en  = 1'b0;
    // Dropping the request anywhere past IDLE abandons the run; words are left as they are
    if (state != IDLE && !start_permutation) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: if (start_permutation) begin
          load_en    = 1'b1;
          cnt_next   = 7'd1;
          state_next = LOAD;
        end
        LOAD: begin
          load_en  = 1'b1;
          cnt_next = cnt + 7'd1;
          if (cnt == LAST) state_next = DIFFUSE;
        end
        DIFFUSE: begin
          diffuse_en = 1'b1;
          cnt_next   = '0;
          state_next = OUTPUT;
        end
        OUTPUT: begin
          rotate_en = 1'b1;
          cnt_next  = cnt + 7'd1;
          if (cnt == LAST) state_next = DONE;
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  perm_state_regs #(.W(BITS_PER_CYCLE)) u_regs (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .diffuse_en (diffuse_en),
    .rotate_en  (rotate_en),
    .input_data (input_data),
    .constant   (constant),
    .top_column (top_column)
  );

  always_comb begin
    output_data = '0;
    if (state == OUTPUT || state == DONE) output_data = top_column;
  end

`ifdef PERM_DONE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perm_done <= 1'b0;
    else      perm_done <= (state == OUTPUT) && (state_next == DONE);
  end
`endif

endmodule

// File: tb/tb_one_round_permutation.sv
// tb/tb_one_round_permutation.sv - scoreboard bench for one_round_permutation with one bit per cycle
module tb_one_round_permutation;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] input_data;
  logic       constant;
  logic       start_permutation;
  logic [4:0] output_data;
`ifdef PERM_DONE_EN
  logic       perm_done;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] stim  [5];
  logic [63:0] exp_w [5];
  logic [63:0] cw;
  logic [4:0]  sb [$];
  int          ra [5] = '{19, 61, 1, 10, 7};
  int          rb [5] = '{28, 39, 6, 17, 41};

  always #5 clk = ~clk;

  one_round_permutation #(.BITS_PER_CYCLE(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .input_data        (input_data),
    .constant          (constant),
    .start_permutation (start_permutation),
    .output_data       (output_data)
`ifdef PERM_DONE_EN
    ,
    .perm_done         (perm_done)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] col_of_exp(input int p);
    return {exp_w[0][p], exp_w[1][p], exp_w[2][p], exp_w[3][p], exp_w[4][p]};
  endfunction

  function automatic logic [4:0] col_of_stim(input int p);
    return {stim[0][p], stim[1][p], stim[2][p], stim[3][p], stim[4][p]};
  endfunction

  // Reference round written in the word-parallel software form of ASCON
  task automatic model_p1();
    logic [63:0] x [5];
    logic [63:0] t [5];
    for (int k = 0; k < 5; k++) x[k] = stim[k];
    x[2] ^= cw;
    x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
    for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k+1)%5];
    for (int k = 0; k < 5; k++) x[k] ^= t[(k+1)%5];
    x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 64; i++)
        exp_w[k][i] = x[k][i] ^ x[k][(i+ra[k])%64] ^ x[k][(i+rb[k])%64];
  endtask

  task automatic drive_cols(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      chk("load_out_zero", 64'(output_data), 64'd0);
      start_permutation = 1'b1;
      input_data        = col_of_stim(63 - i);
      constant          = cw[63 - i];
    end
  endtask

  task automatic run_full(input string tag);
    logic [4:0] first_col;
    for (int i = 0; i < 64; i++) sb.push_back(col_of_exp(63 - i));
    first_col = col_of_exp(63);
    drive_cols(0, 64);
    @(negedge clk);
    chk({tag, "_diffuse_zero"}, 64'(output_data), 64'd0);
    input_data = 5'($urandom);
    constant   = 1'($urandom);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      else chk($sformatf("%s_col%0d", tag, 63 - i), 64'(output_data), 64'(sb.pop_front()));
    end
    @(negedge clk);
    chk({tag, "_done_col"}, 64'(output_data), 64'(first_col));
`ifdef PERM_DONE_EN
    chk({tag, "_done_pulse"}, 64'(perm_done), 64'd1);
`endif
    @(negedge clk);
    chk({tag, "_done_hold"}, 64'(output_data), 64'(first_col));
`ifdef PERM_DONE_EN
    chk({tag, "_done_pulse_end"}, 64'(perm_done), 64'd0);
`endif
    start_permutation = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_zero"}, 64'(output_data), 64'd0);
  endtask

  task automatic set_random_stim();
    for (int k = 0; k < 5; k++) stim[k] = {$urandom, $urandom};
    cw = {$urandom, $urandom};
    model_p1();
  endtask

  initial begin
    rst = 1'b0;
    start_permutation = 1'b0;
    input_data = '0;
    constant = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out", 64'(output_data), 64'd0);
`ifdef PERM_DONE_EN
    chk("reset_done", 64'(perm_done), 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) stim[k] = '0;
    cw = '0;
    exp_w = '{64'd0, 64'd0, '1, 64'd0, 64'd0};
    run_full("zeros");

    for (int k = 0; k < 5; k++) stim[k] = '1;
    exp_w = '{'1, 64'd0, '1, '1, '1};
    run_full("ones");

    for (int k = 0; k < 5; k++) stim[k] = '0;
    cw = 64'd1;
    exp_w = '{64'h0000_2010_0000_0001, 64'h0000_0000_0200_0009,
              64'h7BFF_FFFF_FFFF_FFFE, 64'h0040_8000_0000_0000 | 64'd1, 64'd0};
    run_full("const_bit0");

    stim = '{64'h80400c0600000000, 64'd0, 64'h0000_0000_1215_3524, 64'd0, 64'h0000_0000_c089_5e81};
    cw = 64'h4b;
    model_p1();
    run_full("ascon_init");

    set_random_stim();
    run_full("random");

    // Abandon a load part-way, then a full restart must still produce the right round
    set_random_stim();
    drive_cols(0, 20);
    @(negedge clk);
    start_permutation = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'(output_data), 64'd0);
    set_random_stim();
    run_full("restart");

    // Reset in the middle of streaming out
    set_random_stim();
    for (int i = 0; i < 64; i++) sb.push_back(col_of_exp(63 - i));
    drive_cols(0, 64);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("pre_rst_col%0d", 63 - i), 64'(output_data), 64'(sb.pop_front()));
    end
    rst = 1'b0;
    #1;
    chk("rst_mid_output", 64'(output_data), 64'd0);
    sb.delete();
    start_permutation = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(output_data), 64'd0);
    set_random_stim();
    run_full("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
